regfile_mp: RTL and testbench

Parametrised multi-port register file with write-first bypass, a hardwired zero register and a per-register pending-write scoreboard. Sits in the decode stage and supplies operands to the execute stage. Writeback can retire several results per cycle, and decode can stall on operands whose producing instruction has not yet written back. Single clock domain with an asynchronous clear.

---
 rtl/regfile_mp_pkg.sv | 21 ++
 rtl/regfile_scoreboard.sv | 71 +++++++
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the zero-register index and the write-port priority rule.
package regfile_mp_pkg;

    localparam int WORD  = 64;
    localparam int NREGS = 32;
    localparam int XZR   = 31;

    // When several write ports target one register, the highest-index port wins.
    localparam bit WR_PRIO_HIGH = 1'b1;

    function automatic int addr_width(input int depth);
        return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
    endfunction

    // Port visited at step k of a priority walk; the last port visited wins.
    function automatic int port_at(input int k, input int num_ports);
        return WR_PRIO_HIGH ? k : (num_ports - 32'sd1 - k);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: set by issue, cleared by writeback,
// plus the combinational busy lookup for each read port.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH    = NREGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = XZR,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_addr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [DEPTH-1:0]     busy_vec,
    output logic [NUM_RD-1:0]    rd_busy
);

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_IDX  = (AW+1)'(ZERO_REG);
    localparam bit          BYP_EN    = (BYPASS != 32'sd0);

    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  set_s;
    logic [DEPTH-1:0]  clr_s;
    logic [NUM_RD-1:0] fwd_s;

    // Decode issue and writeback into per-register set/clear strobes.
    always_comb begin
        set_s = '0;
        clr_s = '0;
        for (int r = 0; r < DEPTH; r++) begin
            set_s[r] = iss_valid && (iss_addr == AW'(r)) && (r != ZERO_REG);
            for (int j = 0; j < NUM_WR; j++) begin
                clr_s[r] = clr_s[r] | (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r)));
            end
        end
    end

    // Busy bits; a new producer (set) overrides a retiring one (clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            busy_r <= (busy_r & ~clr_s) | set_s;
        end
    end

    // Operand lookup; a same-cycle write hides the busy bit when it will be forwarded.
    always_comb begin
        fwd_s   = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                fwd_s[i] = fwd_s[i] | (BYP_EN && wr_en[j] &&
                           (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]));
            end
            rd_busy[i] = ({1'b0, rd_addr[i*AW +: AW]} < DEPTH_LIM) &&
                         ({1'b0, rd_addr[i*AW +: AW]} != ZERO_IDX) &&
                         !fwd_s[i] && busy_r[rd_addr[i*AW +: AW]];
        end
    end

    assign busy_vec = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, hardwired zero register
// and registered read ports; pending-write tracking lives in regfile_scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH    = WORD,
    parameter int DEPTH    = NREGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = XZR,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_addr,
    output logic [DEPTH-1:0]        busy_vec
);

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_IDX  = (AW+1)'(ZERO_REG);
    localparam bit          BYP_EN    = (BYPASS != 32'sd0);

    logic [WIDTH-1:0]        regs_r    [DEPTH];
    logic [WIDTH-1:0]        wr_val_s  [DEPTH];
    logic [DEPTH-1:0]        wr_hit_s;
    logic [WIDTH-1:0]        rd_next_s [NUM_RD];
    logic [NUM_RD*WIDTH-1:0] rd_data_r;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_LIM) && ({1'b0, a} != ZERO_IDX);
    endfunction

    // Resolve the winning write per register; zero-register and out-of-range writes never hit.
    always_comb begin
        wr_hit_s = '0;
        for (int r = 0; r < DEPTH; r++) begin
            wr_val_s[r] = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                logic sel;
                sel = wr_en[port_at(k, NUM_WR)] &&
                      (wr_addr[port_at(k, NUM_WR)*AW +: AW] == AW'(r)) &&
                      addr_ok(AW'(r));
                wr_hit_s[r] = wr_hit_s[r] | sel;
                wr_val_s[r] = sel ? wr_data[port_at(k, NUM_WR)*WIDTH +: WIDTH] : wr_val_s[r];
            end
        end
    end

    // Architectural register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (wr_hit_s[r]) begin
                    regs_r[r] <= wr_val_s[r];
                end
            end
        end
    end

    // Read mux: zero for XZR/out-of-range, forwarded write data when bypass is on.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            logic [AW-1:0] a;
            a = rd_addr[i*AW +: AW];
            rd_next_s[i] = !addr_ok(a)                 ? '0 :
                           (BYP_EN && wr_hit_s[a])     ? wr_val_s[a] :
                                                         regs_r[a];
        end
    end

    // Read data registers; a disabled port holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    rd_data_r[i*WIDTH +: WIDTH] <= rd_next_s[i];
                end
            end
        end
    end

    assign rd_data = rd_data_r;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .busy_vec  (busy_vec),
        .rd_busy   (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with bypass, one read-old,
// driven by identical stimulus.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   rd_en;
    logic [9:0]   rd_addr;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic         iss_valid;
    logic [4:0]   iss_addr;

    logic [127:0] rd_data_b, rd_data_o;
    logic [1:0]   rd_busy_b, rd_busy_o;
    logic [31:0]  busy_vec_b, busy_vec_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .busy_vec(busy_vec_b)
    );

    regfile_mp #(.BYPASS(0)) dut_old (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_o), .rd_busy(rd_busy_o), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .busy_vec(busy_vec_o)
    );

    task automatic idle();
        rd_en = 2'b00; rd_addr = 10'd0; wr_en = 2'b00; wr_addr = 10'd0;
        wr_data = 128'd0; iss_valid = 1'b0; iss_addr = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #2;
        total++;
        if ({rd_data_b, rd_data_o} !== 256'd0) begin
            bad++; $display("FAIL reset_rd_data got=%h_%h exp=0", rd_data_b, rd_data_o);
        end
        total++;
        if ({busy_vec_b, busy_vec_o, rd_busy_b, rd_busy_o} !== 68'd0) begin
            bad++; $display("FAIL reset_busy got=%h %h %b %b exp=0", busy_vec_b, busy_vec_o, rd_busy_b, rd_busy_o);
        end
        #10;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rd_en   = 2'b11;
            rd_addr = {5'(k + 16), 5'(k)};
            tick();
            total++;
            if (rd_data_b !== 128'd0 || rd_data_o !== 128'd0) begin
                bad++; $display("FAIL reset_read r%0d/r%0d got=%h %h exp=0", k, k + 16, rd_data_b, rd_data_o);
            end
        end
        total++;
        if (busy_vec_b !== 32'd0) begin
            bad++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec_b);
        end
        idle();
    endtask

    task automatic test_bypass();
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[63:0] = 64'hDEAD_BEEF;
        rd_en = 2'b01; rd_addr[4:0] = 5'd5;
        tick();
        total++;
        if (rd_data_b[63:0] !== 64'hDEAD_BEEF) begin
            bad++; $display("FAIL bypass_fwd got=%h exp=%h", rd_data_b[63:0], 64'hDEAD_BEEF);
        end
        total++;
        if (rd_data_o[63:0] !== 64'd0) begin
            bad++; $display("FAIL readold_same_edge got=%h exp=0", rd_data_o[63:0]);
        end
        idle();
        rd_en = 2'b01; rd_addr[4:0] = 5'd5;
        tick();
        total++;
        if (rd_data_o[63:0] !== 64'hDEAD_BEEF) begin
            bad++; $display("FAIL readold_next got=%h exp=%h", rd_data_o[63:0], 64'hDEAD_BEEF);
        end
        idle();
        rd_addr[4:0] = 5'd0;
        tick();
        total++;
        if (rd_data_b[63:0] !== 64'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_en_hold got=%h exp=%h", rd_data_b[63:0], 64'hDEAD_BEEF);
        end
    endtask

    task automatic test_conflict();
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {64'h22, 64'h11};
        rd_en = 2'b01; rd_addr[4:0] = 5'd7;
        tick();
        total++;
        if (rd_data_b[63:0] !== 64'h22) begin
            bad++; $display("FAIL conflict_fwd got=%h exp=22", rd_data_b[63:0]);
        end
        idle();
        rd_en = 2'b10; rd_addr[9:5] = 5'd7;
        tick();
        total++;
        if (rd_data_b[127:64] !== 64'h22 || rd_data_o[127:64] !== 64'h22) begin
            bad++; $display("FAIL conflict_read got=%h %h exp=22", rd_data_b[127:64], rd_data_o[127:64]);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        wr_en = 2'b01; wr_addr[4:0] = 5'd31; wr_data[63:0] = 64'hFFFF;
        rd_en = 2'b01; rd_addr[4:0] = 5'd31;
        tick();
        total++;
        if (rd_data_b[63:0] !== 64'd0) begin
            bad++; $display("FAIL xzr_no_fwd got=%h exp=0", rd_data_b[63:0]);
        end
        idle();
        rd_en = 2'b11; rd_addr = {5'd7, 5'd31};
        iss_valid = 1'b1; iss_addr = 5'd31;
        tick();
        total++;
        if (rd_data_o[63:0] !== 64'd0 || rd_data_o[127:64] !== 64'h22) begin
            bad++; $display("FAIL xzr_read got=%h exp=%h", rd_data_o, {64'h22, 64'h0});
        end
        idle();
        rd_addr[4:0] = 5'd31;
        #1;
        total++;
        if (busy_vec_b[31] !== 1'b0 || rd_busy_b[0] !== 1'b0) begin
            bad++; $display("FAIL xzr_busy got=%b/%b exp=0/0", busy_vec_b[31], rd_busy_b[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        idle();
        rd_addr[4:0] = 5'd3;
        #1;
        total++;
        if (rd_busy_b[0] !== 1'b1 || rd_busy_o[0] !== 1'b1 || busy_vec_b !== 32'h8) begin
            bad++; $display("FAIL sb_set got=%b %b %h exp=1 1 00000008", rd_busy_b[0], rd_busy_o[0], busy_vec_b);
        end
        wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[63:0] = 64'h33;
        #1;
        total++;
        if (rd_busy_b[0] !== 1'b0 || rd_busy_o[0] !== 1'b1) begin
            bad++; $display("FAIL sb_fwd_mask got=%b %b exp=0 1", rd_busy_b[0], rd_busy_o[0]);
        end
        tick();
        idle();
        total++;
        if (busy_vec_b[3] !== 1'b0 || busy_vec_o[3] !== 1'b0) begin
            bad++; $display("FAIL sb_clear got=%b %b exp=0 0", busy_vec_b[3], busy_vec_o[3]);
        end
        iss_valid = 1'b1; iss_addr = 5'd3;
        wr_en = 2'b10; wr_addr[9:5] = 5'd3; wr_data[127:64] = 64'h44;
        tick();
        idle();
        total++;
        if (busy_vec_b !== 32'h8 || busy_vec_o !== 32'h8) begin
            bad++; $display("FAIL sb_set_wins got=%h %h exp=00000008", busy_vec_b, busy_vec_o);
        end
    endtask

    task automatic test_reset_mid();
        rd_en = 2'b11; rd_addr = {5'd7, 5'd5};
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        total++;
        if (rd_data_b !== {64'h22, 64'hDEAD_BEEF} || busy_vec_b !== 32'h208) begin
            bad++; $display("FAIL pre_reset got=%h %h exp=%h 00000208", rd_data_b, busy_vec_b, {64'h22, 64'hDEAD_BEEF});
        end
        idle();
        wr_en = 2'b01; wr_addr[4:0] = 5'd10; wr_data[63:0] = 64'hAB;
        rd_addr = {5'd9, 5'd3};
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rd_data_b, rd_data_o} !== 256'd0) begin
            bad++; $display("FAIL async_rst_rd_data got=%h %h exp=0", rd_data_b, rd_data_o);
        end
        total++;
        if ({busy_vec_b, busy_vec_o, rd_busy_b, rd_busy_o} !== 68'd0) begin
            bad++; $display("FAIL async_rst_busy got=%h %h %b %b exp=0", busy_vec_b, busy_vec_o, rd_busy_b, rd_busy_o);
        end
        idle();
        #20;
        rst_n = 1'b1;
        rd_en = 2'b11; rd_addr = {5'd10, 5'd5};
        tick();
        total++;
        if (rd_data_b !== 128'd0 || rd_data_o !== 128'd0) begin
            bad++; $display("FAIL post_rst_regs got=%h %h exp=0", rd_data_b, rd_data_o);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_conflict();
        test_zero_reg();
        test_scoreboard();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
